// File: rtl/hello_uart_tx.sv
// hello_uart_tx: pulls words from a sequential source and sends each one
// as an async serial frame (start bit, W data bits LSB first, STOP stop bits).
module hello_uart_tx #(
    parameter int W    = 8,
    parameter int DIV  = 4,
    parameter int STOP = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    output logic         get,
    input  logic [W-1:0] data,
    input  logic         empty,
    output logic         tx,
    output logic         busy,
    output logic         sent,
    output logic [15:0]  frames
);

    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(W + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(W - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("hello_uart_tx: DIV must be >= 2");
        end
        if (STOP != 1 && STOP != 2) begin : g_bad_stop
            $error("hello_uart_tx: STOP must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [BW-1:0] baud_q;
    logic [CW-1:0] bit_q;
    logic [W-1:0]  shreg_q;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        get     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                get = enable & ~empty & reset;
                if (get) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_START;
            S_START: begin
                if (baud_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_end && bit_q == DATA_LAST) state_d = S_STOP;
            end
            S_STOP: begin
                if (baud_end && bit_q == STOP_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // bit_q is reused as the stop-bit counter while in S_STOP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tx      <= 1'b1;
            sent    <= 1'b0;
            frames  <= 16'd0;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            sent    <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    shreg_q <= data;
                    tx      <= 1'b0;
                    baud_q  <= '0;
                    bit_q   <= '0;
                end
                S_START: begin
                    if (baud_end) begin
                        tx      <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        baud_q  <= '0;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == DATA_LAST) begin
                            tx    <= 1'b1;
                            bit_q <= '0;
                        end else begin
                            tx      <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == STOP_LAST) begin
                            sent   <= 1'b1;
                            frames <= frames + 16'd1;
                            bit_q  <= '0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hello_uart_tx.sv
// tb_hello_uart_tx: directed bench, "hello\r\n" source feeding a DIV=4
// and a DIV=2 transmitter, frames decoded cycle by cycle on tx.
module tb_hello_uart_tx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset4, enable4, get4, empty4, tx4, busy4, sent4;
    logic [7:0]  data4;
    logic [15:0] frames4;
    logic        reset2, enable2, get2, empty2, tx2, busy2, sent2;
    logic [7:0]  data2;
    logic [15:0] frames2;

    int   idx4;
    int   idx2;
    int   ng4 = 0;
    logic badget = 1'b0;
    int   errors = 0;
    int   checks = 0;

    hello_uart_tx #(.W(8), .DIV(4), .STOP(1)) dut4 (
        .clock  (clock),
        .reset  (reset4),
        .enable (enable4),
        .get    (get4),
        .data   (data4),
        .empty  (empty4),
        .tx     (tx4),
        .busy   (busy4),
        .sent   (sent4),
        .frames (frames4)
    );

    hello_uart_tx #(.W(8), .DIV(2), .STOP(1)) dut2 (
        .clock  (clock),
        .reset  (reset2),
        .enable (enable2),
        .get    (get2),
        .data   (data2),
        .empty  (empty2),
        .tx     (tx2),
        .busy   (busy2),
        .sent   (sent2),
        .frames (frames2)
    );

    function automatic logic [7:0] rom_at(input int i);
        case (i)
            0:       return 8'h68;
            1:       return 8'h65;
            2:       return 8'h6C;
            3:       return 8'h6C;
            4:       return 8'h6F;
            5:       return 8'h0D;
            6:       return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clock or negedge reset4)
        if (!reset4) begin
            idx4  <= 0;
            data4 <= 8'h00;
        end else if (get4 && !empty4) begin
            data4 <= rom_at(idx4);
            idx4  <= idx4 + 1;
        end
    assign empty4 = (idx4 == 7);

    always @(posedge clock or negedge reset2)
        if (!reset2) begin
            idx2  <= 0;
            data2 <= 8'h00;
        end else if (get2 && !empty2) begin
            data2 <= rom_at(idx2);
            idx2  <= idx2 + 1;
        end
    assign empty2 = (idx2 == 7);

    always @(posedge clock) if (get4) ng4 <= ng4 + 1;
    always @(negedge clock) if (get4 && busy4) badget <= 1'b1;

    function automatic logic txs(input int w);
        return (w == 2) ? tx2 : tx4;
    endfunction

    function automatic logic sents(input int w);
        return (w == 2) ? sent2 : sent4;
    endfunction

    function automatic logic [15:0] framess(input int w);
        return (w == 2) ? frames2 : frames4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input int which, input string tag,
                              output int gap);
        int n;
        gap = 0;
        n = 0;
        @(negedge clock);
        while (txs(which) !== 1'b0 && n < 500) begin
            gap++;
            n++;
            @(negedge clock);
        end
        chk({tag, "_start"}, 64'(txs(which)), 64'd0);
    endtask

    task automatic recv(input int which, input logic [7:0] exp,
                        input int exp_frames, input int drop_at,
                        input string tag, output int gap);
        logic [39:0] obs;
        logic [39:0] expv;
        logic        early;
        int          div;
        int          n;
        div   = (which == 2) ? 2 : 4;
        n     = 10 * div;
        obs   = '0;
        expv  = '0;
        early = 1'b0;
        wait_start(which, tag, gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clock);
            obs[i]  = txs(which);
            expv[i] = (i < div) ? 1'b0 :
                      (i < 9 * div) ? exp[(i - div) / div] : 1'b1;
            if (sents(which)) early = 1'b1;
            if (i == drop_at) enable4 = 1'b0;
        end
        chk({tag, "_bits"}, 64'(obs), 64'(expv));
        chk({tag, "_nosent"}, 64'(early), 64'd0);
        @(negedge clock);
        chk({tag, "_sent"}, 64'(sents(which)), 64'd1);
        chk({tag, "_frames"}, 64'(framess(which)), 64'(exp_frames));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gap;
        int   nb;
        logic bad;
        logic [7:0] hello [0:6];

        hello[0] = 8'h68; hello[1] = 8'h65; hello[2] = 8'h6C;
        hello[3] = 8'h6C; hello[4] = 8'h6F; hello[5] = 8'h0D;
        hello[6] = 8'h0A;

        reset4  = 1'b1;
        reset2  = 1'b1;
        enable4 = 1'b1;
        enable2 = 1'b1;
        #1;
        reset4 = 1'b0;
        reset2 = 1'b0;

        // reset held with data available and enable high
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (tx4 !== 1'b1 || get4 !== 1'b0 || busy4 !== 1'b0 ||
                sent4 !== 1'b0 || frames4 !== 16'd0) bad = 1'b1;
        end
        chk("rst_quiet", 64'(bad), 64'd0);
        chk("rst_tx", 64'(tx4), 64'd1);
        chk("rst_get", 64'(get4), 64'd0);
        chk("rst_frames", 64'(frames4), 64'd0);
        chk("rst_nget", 64'(ng4), 64'd0);

        // full stream
        reset4 = 1'b1;
        recv(4, hello[0], 1, -1, "s0", gap);
        chk("s0_get_once", 64'(ng4), 64'd1);
        for (int k = 1; k < 7; k++) begin
            recv(4, hello[k], k + 1, -1, $sformatf("s%0d", k), gap);
        end
        repeat (20) @(negedge clock);
        chk("end_empty", 64'(empty4), 64'd1);
        chk("end_tx", 64'(tx4), 64'd1);
        chk("end_busy", 64'(busy4), 64'd0);
        chk("end_frames", 64'(frames4), 64'd7);
        chk("end_nget", 64'(ng4), 64'd7);

        // restart, then reset in data bit 3 of the 'e' frame
        @(negedge clock);
        reset4 = 1'b0;
        repeat (2) @(negedge clock);
        chk("rs_frames0", 64'(frames4), 64'd0);
        reset4 = 1'b1;
        nb = ng4;
        recv(4, 8'h68, 1, -1, "rs_h", gap);
        wait_start(4, "rs_e", gap);
        repeat (17) @(negedge clock);
        chk("rs_bit3", 64'(tx4), 64'd0);
        reset4 = 1'b0;
        #1;
        chk("rs_tx", 64'(tx4), 64'd1);
        chk("rs_busy", 64'(busy4), 64'd0);
        chk("rs_frames", 64'(frames4), 64'd0);
        chk("rs_get", 64'(get4), 64'd0);
        repeat (2) @(negedge clock);
        reset4 = 1'b1;
        recv(4, 8'h68, 1, -1, "rr_h", gap);
        chk("rr_nget", 64'(ng4), 64'(nb + 3));

        // enable dropped during DATA of frame 2
        recv(4, 8'h65, 2, 12, "en_e", gap);
        nb = ng4;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (tx4 !== 1'b1 || busy4 !== 1'b0) bad = 1'b1;
        end
        chk("en_hold", 64'(bad), 64'd0);
        chk("en_noget", 64'(ng4), 64'(nb));
        enable4 = 1'b1;
        recv(4, 8'h6C, 3, -1, "en_l", gap);
        chk("en_nget", 64'(ng4), 64'(nb + 1));

        // DIV=2 back-to-back: stop + IDLE + LOAD = 4 high cycles
        @(negedge clock);
        reset2 = 1'b1;
        recv(2, 8'h68, 1, -1, "d2_h", gap);
        recv(2, 8'h65, 2, -1, "d2_e", gap);
        chk("d2_gap1", 64'(2 + 1 + gap), 64'd4);
        recv(2, 8'h6C, 3, -1, "d2_l", gap);
        chk("d2_gap2", 64'(2 + 1 + gap), 64'd4);

        chk("get_only_idle", 64'(badget), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
